core_sequencer: RTL and testbench

- Parametrised instruction sequencer for the simple processor. It is the successor to the fixed start-driven state machine plus control decode.
- Fetches from IRAM and decodes the opcode class. Runs ready/enable handshakes with wait states to IRAM and DRAM, and issues one-cycle strobes to the datapath.
- Adds halt/resume, conditional jump and a wait-state timeout error. Sits between the memories and the processor datapath inside the core.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/core_sequencer_if.sv | 30 +++
 rtl/mem_handshake.sv | 32 +++
 rtl/core_sequencer.sv | 139 +++++++++++++
 tb/tb_core_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types for the instruction sequencer: FSM states,
// opcode map and opcode-class decode.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_LOAD,
        C_STORE,
        C_JMP,
        C_JZ,
        C_ALU,
        C_HALT
    } opc_class_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_JMP    = 4'd3;
    localparam logic [3:0] OP_JZ     = 4'd4;
    localparam logic [3:0] OP_ALU_LO = 4'd5;
    localparam logic [3:0] OP_ALU_HI = 4'd14;
    localparam logic [3:0] OP_HALT   = 4'd15;

    // Anything not matched (including OP_NOP) behaves as NOP.
    function automatic opc_class_t opc_class(input logic [3:0] opc);
        opc_class_t c;
        c = C_NOP;
        unique case (1'b1)
            opc == OP_LOAD:  c = C_LOAD;
            opc == OP_STORE: c = C_STORE;
            opc == OP_JMP:   c = C_JMP;
            opc == OP_JZ:    c = C_JZ;
            opc == OP_HALT:  c = C_HALT;
            (opc >= OP_ALU_LO) && (opc <= OP_ALU_HI): c = C_ALU;
            default:         c = C_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// IRAM and DRAM request/ready bus between the sequencer
// (master) and the memories (slave).
interface core_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              iram_rd_en;
    logic [ADDR_W-1:0] iram_addr;
    logic [DATA_W-1:0] iram_rdata;
    logic              iram_ready;
    logic              dram_rd_en;
    logic              dram_wr_en;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_rdata;
    logic              dram_ready;

    modport master (
        output iram_rd_en, iram_addr,
        input  iram_rdata, iram_ready,
        output dram_rd_en, dram_wr_en, dram_addr,
        input  dram_rdata, dram_ready
    );

    modport slave (
        input  iram_rd_en, iram_addr,
        output iram_rdata, iram_ready,
        input  dram_rd_en, dram_wr_en, dram_addr,
        output dram_rdata, dram_ready
    );
endinterface

// File: rtl/mem_handshake.sv
// Wait-state tracker for one memory port: transfer completion
// and timeout once MAX_WAIT consecutive not-ready cycles pass.
module mem_handshake #(
    parameter int MAX_WAIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req,
    input  logic ready,
    output logic done,
    output logic timeout
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt;

    // Cleared whenever the request is idle, so each new request
    // starts counting from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!req || ready) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done    = req & ready;
    assign timeout = req & ~ready & (cnt == LAST);
endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: fetch, decode, memory handshakes and
// one-cycle datapath strobes, with halt/resume and timeout.
module core_sequencer
    import core_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int OPC_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              zero_flag,
    core_sequencer_if.master  mem,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              ld_en,
    output logic              alu_en,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err
);
    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [ADDR_W-1:0] operand;
    opc_class_t        cls;
    logic              i_req;
    logic              d_req;
    logic              i_done;
    logic              i_tmo;
    logic              d_done;
    logic              d_tmo;
    logic              take_jump;

    assign operand = ir[ADDR_W-1:0];
    assign cls     = opc_class(ir[DATA_W-1 -: OPC_W]);
    assign i_req   = (state == S_FETCH);
    assign d_req   = (state == S_MEM_RD) || (state == S_MEM_WR);

    assign take_jump = (state == S_DECODE) &&
                       ((cls == C_JMP) || ((cls == C_JZ) && zero_flag));

    mem_handshake #(.MAX_WAIT(MAX_WAIT)) u_iram (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (i_req),
        .ready   (mem.iram_ready),
        .done    (i_done),
        .timeout (i_tmo)
    );

    mem_handshake #(.MAX_WAIT(MAX_WAIT)) u_dram (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (d_req),
        .ready   (mem.dram_ready),
        .done    (d_done),
        .timeout (d_tmo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (i_done)     state_nx = S_DECODE;
                else if (i_tmo) state_nx = S_ERROR;
            end
            S_DECODE: begin
                unique case (cls)
                    C_LOAD:  state_nx = S_MEM_RD;
                    C_STORE: state_nx = S_MEM_WR;
                    C_HALT:  state_nx = S_HALT;
                    default: state_nx = S_EXEC;
                endcase
            end
            S_MEM_RD, S_MEM_WR: begin
                if (d_done)     state_nx = S_EXEC;
                else if (d_tmo) state_nx = S_ERROR;
            end
            S_EXEC: begin
                state_nx = halt_req ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) state_nx = S_FETCH;
            end
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc  <= '0;
            ir  <= '0;
            mdr <= '0;
        end else begin
            if ((state == S_IDLE) && start) pc <= '0;
            if (i_done) begin
                ir <= mem.iram_rdata;
                pc <= pc + 1'b1;
            end
            if (take_jump) pc <= operand;
            if (d_done && (state == S_MEM_RD)) mdr <= mem.dram_rdata;
        end
    end

    assign mem.iram_rd_en = i_req;
    assign mem.iram_addr  = pc;
    assign mem.dram_rd_en = (state == S_MEM_RD);
    assign mem.dram_wr_en = (state == S_MEM_WR);
    assign mem.dram_addr  = operand;

    assign pc_out      = pc;
    assign ir_out      = ir;
    assign mdr_out     = mdr;
    assign ld_en       = (state == S_EXEC) && (cls == C_LOAD);
    assign alu_en      = (state == S_EXEC) && (cls == C_ALU);
    assign busy        = (state != S_IDLE) && (state != S_HALT) &&
                         (state != S_ERROR);
    assign halted      = (state == S_HALT);
    assign timeout_err = (state == S_ERROR);
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle vector table for a
// short program plus hand-written multi-cycle sequences.
module tb_core_sequencer;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          halt_req  = 1'b0;
    logic          zero_flag = 1'b0;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] ir_out;
    logic [DW-1:0] mdr_out;
    logic          ld_en;
    logic          alu_en;
    logic          busy;
    logic          halted;
    logic          timeout_err;

    logic [DW-1:0] iram [0:4095];
    logic          iram_rdy  = 1'b1;
    int            dram_dly  = 0;
    int            dcnt      = 0;
    logic [DW-1:0] dram_word = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    core_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

    assign mem.iram_rdata = iram[mem.iram_addr];
    assign mem.iram_ready = iram_rdy;
    assign mem.dram_rdata = dram_word;
    assign mem.dram_ready = (mem.dram_rd_en | mem.dram_wr_en) &&
                            (dcnt >= dram_dly);

    // DRAM model: ready after dram_dly wait cycles of a request
    always @(posedge clock) begin
        dcnt <= (mem.dram_rd_en | mem.dram_wr_en) ? dcnt + 1 : 0;
    end

    core_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .OPC_W(4), .MAX_WAIT(15)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .halt_req    (halt_req),
        .zero_flag   (zero_flag),
        .mem         (mem),
        .pc_out      (pc_out),
        .ir_out      (ir_out),
        .mdr_out     (mdr_out),
        .ld_en       (ld_en),
        .alu_en      (alu_en),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic          start;
        logic          rd;
        logic          alu;
        logic          ld;
        logic          busy;
        logic          halted;
        logic [AW-1:0] pc;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vec_t obs;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd2};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd3};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd3};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd3};

        for (int i = 0; i < 4096; i++) iram[i] = 16'h0000;
        iram[0]     = 16'h0000;
        iram[1]     = 16'h5000;
        iram[2]     = 16'hF000;
        iram[3]     = 16'h102A;
        iram[4]     = 16'h4100;
        iram[5]     = 16'h4100;
        iram[12'h100] = 16'h3FFF;
        iram[12'hFFF] = 16'h3FFF;

        // reset state
        tick();
        chk("reset_ctl",
            {mem.iram_rd_en, mem.dram_rd_en, mem.dram_wr_en, ld_en,
             alu_en, busy, halted, timeout_err}, 8'h00);
        chk("reset_regs", {pc_out, ir_out, mdr_out}, 44'h0);
        reset_n = 1'b1;

        // NOP, ALU, HALT_OP with zero wait states
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start;
            tick();
            obs = '{1'b0, mem.iram_rd_en, alu_en, ld_en, busy,
                    halted, pc_out};
            chk($sformatf("tbl[%0d]", i), 64'(obs[16:0]),
                64'(tbl[i][16:0]));
        end

        // resume into LOAD 0x02A with 3 DRAM wait cycles
        start = 1'b1;
        tick();
        chk("resume_fetch", {mem.iram_rd_en, pc_out}, {1'b1, 12'd3});
        start     = 1'b0;
        dram_dly  = 3;
        dram_word = 16'hA5C3;
        tick();
        tick();
        n = 0;
        while (mem.dram_rd_en && n < 20) begin
            chk("ld_addr", mem.dram_addr, 12'h02A);
            n++;
            tick();
        end
        chk("ld_hold", n, 4);
        chk("ld_mdr", mdr_out, 16'hA5C3);
        chk("ld_strobe", {ld_en, alu_en}, 2'b10);
        tick();
        chk("ld_once", {ld_en, mem.iram_rd_en, pc_out},
            {1'b0, 1'b1, 12'd4});

        // JZ not taken, then JZ taken, then JMP wrap at 0xFFF
        zero_flag = 1'b0;
        tick();
        tick();
        chk("jz_not_taken", pc_out, 12'd5);
        zero_flag = 1'b1;
        tick();
        tick();
        tick();
        chk("jz_taken_pc", pc_out, 12'h100);
        zero_flag = 1'b0;
        tick();
        chk("jz_taken_fetch", {mem.iram_rd_en, mem.iram_addr},
            {1'b1, 12'h100});
        tick();
        tick();
        chk("jmp_pc", pc_out, 12'hFFF);
        tick();
        chk("jmp_fetch_fff", mem.iram_addr, 12'hFFF);
        tick();
        chk("pc_wrap", pc_out, 12'h000);
        halt_req = 1'b1;
        tick();
        tick();
        chk("halt_at_exec", {halted, busy, pc_out}, {1'b1, 1'b0, 12'hFFF});
        halt_req = 1'b0;

        // asynchronous reset while DRAM read is pending
        do_reset();
        iram[0]  = 16'h1010;
        dram_dly = 10;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_rd_active", {mem.dram_rd_en, busy}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ctl",
            {mem.iram_rd_en, mem.dram_rd_en, mem.dram_wr_en, ld_en,
             alu_en, busy, halted, timeout_err}, 8'h00);
        chk("async_rst_regs", {pc_out, ir_out, mdr_out}, 44'h0);
        tick();
        reset_n = 1'b1;

        // STORE with halt_req raised during the DRAM wait
        iram[0]  = 16'h2055;
        iram[1]  = 16'h6000;
        dram_dly = 2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        halt_req = 1'b1;
        n = 0;
        while (mem.dram_wr_en && n < 20) begin
            chk("st_addr", mem.dram_addr, 12'h055);
            n++;
            tick();
        end
        chk("st_hold", n, 3);
        chk("st_exec", {busy, halted}, 2'b10);
        tick();
        chk("st_halt", {halted, pc_out}, {1'b1, 12'd1});
        halt_req = 1'b0;
        start    = 1'b1;
        tick();
        chk("st_resume", {mem.iram_rd_en, mem.iram_addr}, {1'b1, 12'd1});
        start = 1'b0;
        tick();
        tick();
        chk("st_resume_alu", {alu_en, ir_out}, {1'b1, 16'h6000});

        // IRAM never ready: timeout after 15 wait cycles
        do_reset();
        iram_rdy = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (mem.iram_rd_en && n < 40) begin
            n++;
            tick();
        end
        chk("tmo_cycles", n, 15);
        chk("tmo_state", {timeout_err, mem.iram_rd_en, busy}, 3'b100);
        start = 1'b1;
        tick();
        tick();
        chk("tmo_sticky", {timeout_err, mem.iram_rd_en, busy}, 3'b100);
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
